// File: rtl/key_expansion_pkg.sv
// Shared AES-128 key schedule definitions: widths, round count,
// S-box table, GF(2^8) xtime helper and FSM state encoding.
package key_expansion_pkg;

   localparam int Nb = 128;
   localparam int NR = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EMIT,
      ST_DONE
   } state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Handshake/bus bundle for key_expansion.
// slave: key_expansion side; master: round controller side.
interface key_expansion_if;
   import key_expansion_pkg::*;

   logic          start;
   logic [Nb-1:0] key_in;
   logic          rk_ready;
   logic          rk_valid;
   logic [3:0]    rk_round;
   logic [Nb-1:0] rk_out;
   logic          busy;
   logic          done;
   logic [3:0]    rd_round;
   logic [Nb-1:0] rd_key;

   modport master (
      output start, key_in, rk_ready, rd_round,
      input  rk_valid, rk_round, rk_out, busy, done, rd_key
   );

   modport slave (
      input  start, key_in, rk_ready, rd_round,
      output rk_valid, rk_round, rk_out, busy, done, rd_key
   );

endinterface

// File: rtl/key_expansion_sub_word.sv
// SubWord: four parallel S-box byte lookups on a 32-bit word.
// Ports: word_i (32-bit in), word_o (32-bit substituted out).
module key_expansion_sub_word
   import key_expansion_pkg::*;
(
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign word_o[8*i +: 8] = SBOX[word_i[8*i +: 8]];
   end

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one round key (0..NR) per
// rk_valid/rk_ready handshake, done pulse after the last one.
// Ports: clk, rst_n (sync, active-low), bus (key_expansion_if.slave).
// Define KEY_EXP_STORE_EN to add an 11-entry round-key store read
// through rd_round/rd_key; otherwise rd_key is tied to 0.
module key_expansion
   import key_expansion_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   key_expansion_if.slave bus
);

   state_e        state_q, state_d;
   logic          rk_valid_q, rk_valid_d;
   logic [3:0]    rk_round_q, rk_round_d;
   logic [Nb-1:0] rk_out_q, rk_out_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [7:0]    rcon_q, rcon_d;

   logic          accept;
   logic          load;
   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   rot_w, sub_w, t_w;
   logic [31:0]   n0, n1, n2, n3;

   assign accept = rk_valid_q & bus.rk_ready;
   assign load   = (state_q == ST_IDLE) & bus.start;

   assign w0 = rk_out_q[127:96];
   assign w1 = rk_out_q[95:64];
   assign w2 = rk_out_q[63:32];
   assign w3 = rk_out_q[31:0];

   assign rot_w = {w3[23:0], w3[31:24]};

   key_expansion_sub_word u_sub_word (
      .word_i (rot_w),
      .word_o (sub_w)
   );

   assign t_w = sub_w ^ {rcon_q, 24'h0};
   assign n0  = w0 ^ t_w;
   assign n1  = n0 ^ w1;
   assign n2  = n1 ^ w2;
   assign n3  = n2 ^ w3;

   always_comb begin
      state_d    = state_q;
      rk_valid_d = rk_valid_q;
      rk_round_d = rk_round_q;
      rk_out_d   = rk_out_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rcon_d     = rcon_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d    = ST_EMIT;
               rk_out_d   = bus.key_in;
               rk_round_d = 4'd0;
               rcon_d     = 8'h01;
               rk_valid_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         ST_EMIT: begin
            if (accept) begin
               if (rk_round_q == 4'(NR)) begin
                  state_d    = ST_DONE;
                  rk_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  rk_out_d   = {n0, n1, n2, n3};
                  rk_round_d = rk_round_q + 4'd1;
                  rcon_d     = xtime(rcon_q);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rk_valid_q <= 1'b0;
         rk_round_q <= 4'd0;
         rk_out_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rcon_q     <= 8'h01;
      end else begin
         state_q    <= state_d;
         rk_valid_q <= rk_valid_d;
         rk_round_q <= rk_round_d;
         rk_out_q   <= rk_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rcon_q     <= rcon_d;
      end
   end

   assign bus.rk_valid = rk_valid_q;
   assign bus.rk_round = rk_round_q;
   assign bus.rk_out   = rk_out_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

`ifdef KEY_EXP_STORE_EN
   logic [Nb-1:0] store_q [NR+1];
   logic [Nb-1:0] store_d [NR+1];
   logic [Nb-1:0] rd_key_c;

   // Store is wiped when a new schedule loads, then each key is
   // captured on the edge it is handed off.
   always_comb begin
      for (int i = 0; i <= NR; i++) begin
         store_d[i] = store_q[i];
         if (load) begin
            store_d[i] = '0;
         end else if (accept && rk_round_q == 4'(i)) begin
            store_d[i] = rk_out_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i <= NR; i++) begin
         if (!rst_n) begin
            store_q[i] <= '0;
         end else begin
            store_q[i] <= store_d[i];
         end
      end
   end

   // Out-of-range indices fall through to zero.
   always_comb begin
      rd_key_c = '0;
      for (int i = 0; i <= NR; i++) begin
         if (bus.rd_round == 4'(i)) begin
            rd_key_c = store_q[i];
         end
      end
   end

   assign bus.rd_key = rd_key_c;
`else
   logic unused_rd_round;

   assign unused_rd_round = ^{bus.rd_round, load};
   assign bus.rd_key      = '0;
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: FIPS-197 vectors through a scoreboard,
// stalls, ignored starts, mid-schedule reset, back-to-back starts.
module tb_key_expansion;

   typedef struct {
      logic [3:0]   rnd;
      logic [127:0] key;
   } rk_vec_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   key_expansion_if intf ();

   key_expansion dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (intf)
   );

   int total = 0;
   int bad   = 0;

   rk_vec_t fips [11];
   rk_vec_t zk   [4];
   rk_vec_t sb   [$];

   logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic         hold_chk = 1'b0;
   logic [127:0] held_key;
   logic [3:0]   held_rnd;
   rk_vec_t      mon_e;

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Scoreboard side: every accepted key is popped and compared;
   // a key held under rk_ready=0 must not move.
   always @(negedge clk) begin
      if (hold_chk && intf.rk_valid) begin
         chk("hold_key", intf.rk_out, held_key);
         chk("hold_round", 128'(intf.rk_round), 128'(held_rnd));
      end
      if (intf.rk_valid && intf.rk_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_key", 128'(intf.rk_round), 128'hx);
         end else begin
            mon_e = sb.pop_front();
            chk("rk_round", 128'(intf.rk_round), 128'(mon_e.rnd));
            chk("rk_out", intf.rk_out, mon_e.key);
         end
      end
      hold_chk = intf.rk_valid && !intf.rk_ready && rst_n;
      held_key = intf.rk_out;
      held_rnd = intf.rk_round;
   end

   task automatic load_sb(input bit zero);
      if (zero) begin
         for (int i = 0; i < 4; i++) sb.push_back(zk[i]);
      end else begin
         for (int i = 0; i < 11; i++) sb.push_back(fips[i]);
      end
   endtask

   task automatic kick(input logic [127:0] k);
      intf.start  = 1'b1;
      intf.key_in = k;
      @(posedge clk);
      #1;
      intf.start = 1'b0;
   endtask

   // Called #1 after the start edge. mode 1 = random rk_ready.
   // glitch_c: cycle with start=1/key_in=0; rst_c: cycle with rst_n=0.
   task automatic run(input int mode, input int glitch_c,
                      input int rst_c, output int done_c,
                      output int stalls);
      done_c = 0;
      stalls = 0;
      for (int c = 1; c <= 200; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         intf.start = 1'b0;
         rst_n      = 1'b1;
         intf.rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (c == glitch_c) begin
            intf.start  = 1'b1;
            intf.key_in = '0;
         end
         if (c == rst_c) begin
            rst_n         = 1'b0;
            intf.rk_ready = 1'b0;
         end
         @(negedge clk);
         if (c == glitch_c) chk("busy_at_glitch", 128'(intf.busy), 128'd1);
         if (intf.rk_valid && !intf.rk_ready) stalls++;
         if (c == rst_c) break;
         if (intf.done) begin
            chk("done_busy", 128'(intf.busy), 128'd0);
            chk("done_valid", 128'(intf.rk_valid), 128'd0);
            done_c = c;
            break;
         end
      end
      intf.start = 1'b0;
   endtask

   task automatic finish_chk(input int dc, input int stalls);
      chk("done_cycle", 128'(dc), 128'(12 + stalls));
      chk("sb_left", 128'(sb.size()), 128'd0);
   endtask

   // Next edge applies reset (rst_n already 0); release and check.
   task automatic release_chk();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      intf.rk_ready = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("rst_valid", 128'(intf.rk_valid), 128'd0);
      chk("rst_round", 128'(intf.rk_round), 128'd0);
      chk("rst_out", intf.rk_out, 128'd0);
      chk("rst_busy", 128'(intf.busy), 128'd0);
      chk("rst_done", 128'(intf.done), 128'd0);
      intf.rd_round = 4'd1;
      #1;
      chk("rst_rd_key", intf.rd_key, 128'd0);
   endtask

   initial begin
      int dc;
      int st;

      fips[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
      fips[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      fips[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      fips[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
      fips[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
      fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
      fips[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
      fips[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
      fips[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
      fips[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
      fips[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      zk[0] = '{4'd0, 128'h00000000000000000000000000000000};
      zk[1] = '{4'd1, 128'h62636363626363636263636362636363};
      zk[2] = '{4'd2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
      zk[3] = '{4'd3, 128'h90973450696ccffaf2f457330b0fac99};

      rst_n         = 1'b0;
      intf.start    = 1'b0;
      intf.key_in   = '0;
      intf.rk_ready = 1'b0;
      intf.rd_round = 4'd0;
      repeat (2) @(posedge clk);
      release_chk();

      // Plain FIPS run, rk_ready high.
      load_sb(1'b0);
      kick(fips_key);
      run(0, 0, 0, dc, st);
      finish_chk(dc, st);
      @(negedge clk);
      chk("done_pulse_len", 128'(intf.done), 128'd0);

`ifdef KEY_EXP_STORE_EN
      intf.rd_round = 4'd1;
      #1 chk("rd_1", intf.rd_key, fips[1].key);
      intf.rd_round = 4'd10;
      #1 chk("rd_10", intf.rd_key, fips[10].key);
      intf.rd_round = 4'd11;
      #1 chk("rd_11", intf.rd_key, 128'd0);
      intf.rd_round = 4'd0;
      #1 chk("rd_0", intf.rd_key, fips[0].key);
`else
      intf.rd_round = 4'd1;
      #1 chk("rd_tied0", intf.rd_key, 128'd0);
`endif

      // Random back-pressure.
      @(posedge clk);
      #1;
      load_sb(1'b0);
      kick(fips_key);
      run(1, 0, 0, dc, st);
      finish_chk(dc, st);

      // start/key change during round 4 is ignored.
      @(posedge clk);
      #1;
      load_sb(1'b0);
      kick(fips_key);
      run(0, 5, 0, dc, st);
      finish_chk(dc, st);

      // Reset while round 6 is shown.
      @(posedge clk);
      #1;
      load_sb(1'b0);
      kick(fips_key);
      run(0, 0, 7, dc, st);
      release_chk();

      // Zero key, then reset while round 4 is shown.
      load_sb(1'b1);
      kick(128'd0);
      run(0, 0, 5, dc, st);
      chk("zk_sb_left", 128'(sb.size()), 128'd0);
      release_chk();

      // Back-to-back: start in DONE ignored, next cycle accepted.
      load_sb(1'b0);
      kick(fips_key);
      run(0, 0, 0, dc, st);
      finish_chk(dc, st);
      intf.start  = 1'b1;
      intf.key_in = fips_key;
      load_sb(1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("b2b_ignored_valid", 128'(intf.rk_valid), 128'd0);
      chk("b2b_ignored_busy", 128'(intf.busy), 128'd0);
      @(posedge clk);
      #1;
      intf.start = 1'b0;
      run(0, 0, 0, dc, st);
      finish_chk(dc, st);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
